uart_apb_seq: RTL and testbench
===============================

Name: uart_apb_seq

Overview:
- APB master sequencer that drives one apb_uart slave.
- On cfg_start it writes LCR, FCR, HCR and OCR in that order.
- It then accepts bytes on a valid/ready stream. Per byte: poll the FIFO status register until the TX FIFO is not full, write the byte to TDR, then kick transmission by writing OCR with the start bit set.
- It replaces hand-coded APB write/read sequences at SoC level, and sits between the system control logic and the UART's APB slave port.

Parameters:
- ADDR_W, 12, APB address width
- A_LCR / A_FCR / A_HCR / A_OCR / A_TDR / A_FSR, common_pkg ADDR_LCR / ADDR_FCR / ADDR_HCR / ADDR_OCR / ADDR_TDR / ADDR_FSR, register addresses
- TXFULL_BIT, 0, bit of the FSR read data meaning TX FIFO full
- START_MASK, 8'h02, OR-ed into cfg_ocr for the kick write
- POLL_MAX, 16, maximum FSR reads per byte before error (≥1)
- PREADY_TO, 255, pready wait limit in cycles (optional feature only)

Ports:
- pclk  in  1  clock
- preset  in  1  synchronous active-high reset
- cfg_start  in  1  pulse; begins config sequence; ignored while busy
- cfg_stop  in  1  leave streaming mode
- cfg_lcr / cfg_fcr / cfg_hcr / cfg_ocr  in  8 each  configuration byte values
- tx_data  in  8  byte to send
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  byte accepted when tx_valid & tx_ready
- busy  out  1  not IDLE
- done  out  1  one-cycle pulse on return to IDLE without error
- err  out  1  sticky; cleared by cfg_start
- psel, penable, pwrite  out  1 each  APB master controls
- paddr  out  ADDR_W  APB address
- pstrb  out  4  write strobes
- pwdata  out  32  write data
- prdata  in  32  read data
- pready  in  1  slave ready
- pslverr  in  1  slave error

Behaviour:
- Reset: preset is sampled on pclk. All outputs go to 0 at the next edge, state goes to IDLE, and holding registers clear.
  - A reset during SETUP or ACCESS drops psel immediately; the transfer is abandoned.
- APB engine, per transfer:
  - SETUP for 1 cycle: psel=1, penable=0, address/data/strobe stable.
  - ACCESS: psel=1, penable=1, held until pready=1.
  - Cycle after completion: psel=0, penable=0. At least one idle cycle between transfers.
  - paddr, pwdata, pwrite and pstrb stay stable from SETUP through the last ACCESS cycle.
  - Minimum transfer is 3 cycles including the idle cycle.
- Writes: pwdata = {24'b0, byte}, pstrb = 4'h1.
- Reads: pwrite=0, pstrb = 4'h0, pwdata = 0. prdata is captured on the completing ACCESS edge.
- Sequence states:
  - IDLE → on cfg_start: clear err, latch the four cfg_* bytes, go to CFG.
  - CFG: four writes in order LCR, FCR, HCR, OCR (2-bit index) → READY.
  - READY: tx_ready = ~cfg_stop.
    - cfg_stop=1 → IDLE, done pulses. cfg_stop has priority over tx_valid in the same cycle.
    - Handshake → latch tx_data, clear poll counter, go to POLL.
  - POLL: read A_FSR.
    - Bit TXFULL_BIT = 0 → TDR.
    - Bit = 1 → increment counter and re-read.
    - The POLL_MAX-th read still full → set err, go to IDLE (no done).
  - TDR: write the byte to A_TDR → KICK.
  - KICK: write (cfg_ocr | START_MASK) to A_OCR → READY.
- tx_ready is 0 in every state except READY. Only one byte is in flight.
- pslverr=1 on any completing transfer: set err, abandon the sequence, go to IDLE after that transfer; done does not pulse.
- cfg_start while busy is ignored. The latched cfg bytes stay constant for the whole session.
- Latency: cfg_start to first tx_ready = 4 × 3 cycles + 1 with zero-wait slaves. Byte throughput with zero waits and no full polls is 1 byte per 10 cycles.

Optional Feature:
- UART_SEQ_PREADY_TIMEOUT_EN defined: an 8-bit counter runs in ACCESS.
  - If pready stays 0 for PREADY_TO consecutive ACCESS cycles: drop psel and penable next cycle, set err, go to IDLE.
- Macro undefined: ACCESS waits for pready indefinitely; no counter is synthesized.

Test Plan:
- Config: cfg_start with lcr=03, fcr=01, hcr=01, ocr=05, zero-wait slave → writes to LCR/FCR/HCR/OCR with pwdata 3,1,1,5 and pstrb 1; tx_ready=1 at cycle 13 after cfg_start.
- Single byte 8'h0A, FSR returns 0 → read FSR, write TDR=0x0A, write OCR=0x07; tx_ready=1 again 10 cycles after the handshake; cfg_stop → done pulse, busy=0.
- FSR returns TXFULL for 3 reads then 0 → exactly 4 FSR reads then the TDR write. With POLL_MAX=4 and full forever → 4 reads, err=1, no TDR write, done=0.
- Slave inserts 5 wait states on every transfer, and pslverr=1 on the HCR write → signals stable through the waits, OCR never written, err=1, IDLE; the next cfg_start clears err.
- preset asserted during ACCESS of the TDR write → psel=0 at the next edge, all outputs 0; a subsequent cfg_start works normally. cfg_stop and tx_valid in the same cycle → no byte accepted.
- With UART_SEQ_PREADY_TIMEOUT_EN and PREADY_TO=8, pready held 0 → psel drops after 8 ACCESS cycles, err=1.

Source files
------------

// File: rtl/common_pkg.sv
// Shared register map of the apb_uart slave.
// Provides the default addresses used by the APB sequencer.
package common_pkg;
    localparam logic [11:0] ADDR_LCR = 12'h000;
    localparam logic [11:0] ADDR_FCR = 12'h004;
    localparam logic [11:0] ADDR_HCR = 12'h008;
    localparam logic [11:0] ADDR_OCR = 12'h00C;
    localparam logic [11:0] ADDR_TDR = 12'h010;
    localparam logic [11:0] ADDR_FSR = 12'h014;
endpackage

// File: rtl/uart_apb_seq.sv
// APB master that configures an apb_uart (LCR, FCR, HCR, OCR) and then streams bytes into its TX FIFO.
// Build macro UART_SEQ_PREADY_TIMEOUT_EN adds an ACCESS-phase pready timeout of PREADY_TO cycles.
module uart_apb_seq #(
    parameter int                ADDR_W     = 12,
    parameter logic [ADDR_W-1:0] A_LCR      = ADDR_W'(common_pkg::ADDR_LCR),
    parameter logic [ADDR_W-1:0] A_FCR      = ADDR_W'(common_pkg::ADDR_FCR),
    parameter logic [ADDR_W-1:0] A_HCR      = ADDR_W'(common_pkg::ADDR_HCR),
    parameter logic [ADDR_W-1:0] A_OCR      = ADDR_W'(common_pkg::ADDR_OCR),
    parameter logic [ADDR_W-1:0] A_TDR      = ADDR_W'(common_pkg::ADDR_TDR),
    parameter logic [ADDR_W-1:0] A_FSR      = ADDR_W'(common_pkg::ADDR_FSR),
    parameter int                TXFULL_BIT = 0,
    parameter logic [7:0]        START_MASK = 8'h02,
    parameter int                POLL_MAX   = 16
`ifdef UART_SEQ_PREADY_TIMEOUT_EN
    ,
    parameter int                PREADY_TO  = 255
`endif
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              cfg_start,
    input  logic              cfg_stop,
    input  logic [7:0]        cfg_lcr,
    input  logic [7:0]        cfg_fcr,
    input  logic [7:0]        cfg_hcr,
    input  logic [7:0]        cfg_ocr,
    input  logic [7:0]        tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [3:0]        pstrb,
    output logic [31:0]       pwdata,
    input  logic [31:0]       prdata,
    input  logic              pready,
    input  logic              pslverr
);
    localparam int PW = (POLL_MAX > 1) ? $clog2(POLL_MAX) : 1;
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX - 1);

    typedef enum logic [2:0] {S_IDLE, S_CFG, S_READY, S_POLL, S_TDR, S_KICK} seq_e;
    typedef enum logic [1:0] {PH_GAP, PH_SETUP, PH_ACCESS} phase_e;

    seq_e          state, state_next;
    phase_e        phase, phase_next;
    logic [1:0]    idx, idx_next;
    logic [PW-1:0] poll_cnt, poll_next;
    logic          err_next, done_next, latch_cfg, latch_byte, xfer_done, abort;
    logic [7:0]    lcr_q, fcr_q, hcr_q, ocr_q, byte_q;
    logic [ADDR_W-1:0] addr_sel;
    logic [7:0]    wbyte;
    logic          is_write;

    // Only the TX-full flag of the status word is consumed.
    logic          prdata_unused;
    assign prdata_unused = ^prdata;

`ifdef UART_SEQ_PREADY_TIMEOUT_EN
    logic [7:0] to_cnt;
    always_ff @(posedge pclk) begin
        if (preset || phase != PH_ACCESS) to_cnt <= '0;
        else                              to_cnt <= to_cnt + 8'd1;
    end
`endif

    always_comb begin
        // NOTE: every next-state signal gets a default first, so no path can infer a latch.
        state_next = state;
        phase_next = phase;
        idx_next   = idx;
        poll_next  = poll_cnt;
        err_next   = err;
        done_next  = 1'b0;
        latch_cfg  = 1'b0;
        latch_byte = 1'b0;
        xfer_done  = (phase == PH_ACCESS) && pready;
        abort      = 1'b0;
`ifdef UART_SEQ_PREADY_TIMEOUT_EN
        abort = (phase == PH_ACCESS) && !pready && (to_cnt == 8'(PREADY_TO - 1));
`endif
        case (state)
            S_IDLE: if (cfg_start) begin
                state_next = S_CFG;
                err_next   = 1'b0;
                latch_cfg  = 1'b1;
                idx_next   = 2'd0;
            end
            S_READY: if (cfg_stop) begin
                state_next = S_IDLE;
                done_next  = 1'b1;
            end else if (tx_valid) begin
                latch_byte = 1'b1;
                poll_next  = '0;
                state_next = S_POLL;
            end
            default: begin
                case (phase)
                    PH_GAP:   phase_next = PH_SETUP;
                    PH_SETUP: phase_next = PH_ACCESS;
                    default: if (xfer_done) begin
                        phase_next = PH_GAP;
                        if (pslverr) begin
                            err_next   = 1'b1;
                            state_next = S_IDLE;
                        end else begin
                            case (state)
                                S_CFG: begin
                                    idx_next = idx + 2'd1;
                                    if (idx == 2'd3) state_next = S_READY;
                                end
                                S_POLL: if (!prdata[TXFULL_BIT]) begin
                                    state_next = S_TDR;
                                end else if (poll_cnt == POLL_LAST) begin
                                    err_next   = 1'b1;
                                    state_next = S_IDLE;
                                end else begin
                                    poll_next = poll_cnt + PW'(1);
                                end
                                S_TDR:   state_next = S_KICK;
                                default: state_next = S_READY;
                            endcase
                        end
                    end else if (abort) begin
                        phase_next = PH_GAP;
                        err_next   = 1'b1;
                        state_next = S_IDLE;
                    end
                endcase
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state    <= S_IDLE;
            phase    <= PH_GAP;
            idx      <= '0;
            poll_cnt <= '0;
            err      <= 1'b0;
            done     <= 1'b0;
            lcr_q    <= '0;
            fcr_q    <= '0;
            hcr_q    <= '0;
            ocr_q    <= '0;
            byte_q   <= '0;
        end else begin
            state    <= state_next;
            phase    <= phase_next;
            idx      <= idx_next;
            poll_cnt <= poll_next;
            err      <= err_next;
            done     <= done_next;
            if (latch_cfg) begin
                lcr_q <= cfg_lcr;
                fcr_q <= cfg_fcr;
                hcr_q <= cfg_hcr;
                ocr_q <= cfg_ocr;
            end
            if (latch_byte) byte_q <= tx_data;
        end
    end

    // Bus fields come from registered state only, so they hold from SETUP through ACCESS.
    always_comb begin
        addr_sel = '0;
        wbyte    = '0;
        is_write = 1'b1;
        case (state)
            S_CFG: begin
                case (idx)
                    2'd0: begin addr_sel = A_LCR; wbyte = lcr_q; end
                    2'd1: begin addr_sel = A_FCR; wbyte = fcr_q; end
                    2'd2: begin addr_sel = A_HCR; wbyte = hcr_q; end
                    default: begin addr_sel = A_OCR; wbyte = ocr_q; end
                endcase
            end
            S_POLL: begin addr_sel = A_FSR; is_write = 1'b0; end
            S_TDR:  begin addr_sel = A_TDR; wbyte = byte_q; end
            S_KICK: begin addr_sel = A_OCR; wbyte = ocr_q | START_MASK; end
            default: is_write = 1'b0;
        endcase
    end

    assign psel     = (phase != PH_GAP);
    assign penable  = (phase == PH_ACCESS);
    assign paddr    = psel ? addr_sel : '0;
    assign pwrite   = psel && is_write;
    assign pstrb    = pwrite ? 4'h1 : 4'h0;
    assign pwdata   = pwrite ? {24'b0, wbyte} : 32'b0;
    assign busy     = (state != S_IDLE);
    assign tx_ready = (state == S_READY) && !cfg_stop;
endmodule

// File: tb/tb_uart_apb_seq.sv
// Self-checking bench for uart_apb_seq: scripted APB slave, transaction log and a
// transaction-level reference model of the expected bus traffic and latencies.
module tb_uart_apb_seq;
    import common_pkg::*;

    localparam int         ADDR_W     = 12;
    localparam int         POLL_MAX   = 4;
    localparam logic [7:0] START_MASK = 8'h02;

    typedef struct packed {
        logic              w;
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
        logic [3:0]        s;
    } xfer_t;

    logic              pclk, preset, cfg_start, cfg_stop;
    logic [7:0]        cfg_lcr, cfg_fcr, cfg_hcr, cfg_ocr, tx_data;
    logic              tx_valid, tx_ready, busy, done, err;
    logic              psel, penable, pwrite, pready, pslverr;
    logic [ADDR_W-1:0] paddr;
    logic [3:0]        pstrb;
    logic [31:0]       pwdata, prdata;

    int checks   = 0;
    int failures = 0;

    xfer_t seen_q[$];
    xfer_t exp_q[$];

    int                slv_waits    = 0;
    int                full_left    = 0;
    bit                full_forever = 1'b0;
    bit                err_en       = 1'b0;
    logic [ADDR_W-1:0] err_addr     = '0;
    bit                hold_en      = 1'b0;
    logic [ADDR_W-1:0] hold_addr    = '0;
    logic [7:0]        sess_ocr     = '0;

    uart_apb_seq #(.ADDR_W(ADDR_W), .POLL_MAX(POLL_MAX)) dut (
        .pclk(pclk), .preset(preset), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
        .cfg_lcr(cfg_lcr), .cfg_fcr(cfg_fcr), .cfg_hcr(cfg_hcr), .cfg_ocr(cfg_ocr),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .done(done), .err(err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pstrb(pstrb), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before 500000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic xfer_t wr(input logic [ADDR_W-1:0] a, input logic [7:0] b);
        return {1'b1, a, {24'b0, b}, 4'h1};
    endfunction

    function automatic xfer_t rd(input logic [ADDR_W-1:0] a);
        return {1'b0, a, 32'b0, 4'h0};
    endfunction

    // APB slave: scripted waits/errors/FSR values, logs each completed transfer, checks protocol.
    initial begin : slave
        int    wait_cnt;
        xfer_t lat;
        bit    just_done;
        wait_cnt = 0; lat = '0; just_done = 1'b0;
        pready = 1'b0; pslverr = 1'b0; prdata = '0;
        forever begin
            @(negedge pclk);
            pready = 1'b0; pslverr = 1'b0; prdata = '0;
            if (just_done) check("apb_idle_gap_psel", psel, 1'b0);
            just_done = 1'b0;
            if (psel && !penable) begin
                lat = {pwrite, paddr, pwdata, pstrb};
                wait_cnt = 0;
            end else if (psel && penable) begin
                check("apb_access_stable", {pwrite, paddr, pwdata, pstrb}, lat);
                if (!(hold_en && paddr == hold_addr) && wait_cnt >= slv_waits) begin
                    pready = 1'b1;
                    just_done = 1'b1;
                    if (!pwrite) begin
                        if (full_forever || full_left > 0) begin
                            prdata = $urandom() | 32'h1;
                            if (full_left > 0) full_left--;
                        end else begin
                            prdata = $urandom() & ~32'h1;
                        end
                    end
                    pslverr = err_en && (paddr == err_addr);
                    seen_q.push_back(lat);
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic check_log(input string tag);
        check({tag, "_xfer_count"}, seen_q.size(), exp_q.size());
        for (int i = 0; i < seen_q.size() && i < exp_q.size(); i++)
            check({tag, "_xfer"}, seen_q[i], exp_q[i]);
        seen_q.delete();
        exp_q.delete();
    endtask

    task automatic exp_cfg(input logic [7:0] l, f, h, o, input int n);
        xfer_t all[4];
        all[0] = wr(ADDR_LCR, l);
        all[1] = wr(ADDR_FCR, f);
        all[2] = wr(ADDR_HCR, h);
        all[3] = wr(ADDR_OCR, o);
        for (int i = 0; i < n; i++) exp_q.push_back(all[i]);
    endtask

    task automatic start(input logic [7:0] l, f, h, o);
        cfg_lcr = l; cfg_fcr = f; cfg_hcr = h; cfg_ocr = o;
        sess_ocr  = o;
        cfg_start = 1'b1;
    endtask

    // Counts negedges from the request until tx_ready; strobes are dropped and inputs scrambled.
    task automatic wait_ready(input int budget, output int n);
        n = 0;
        do begin
            @(negedge pclk);
            cfg_start = 1'b0;
            tx_valid  = 1'b0;
            cfg_lcr = 8'($urandom()); cfg_fcr = 8'($urandom());
            cfg_hcr = 8'($urandom()); cfg_ocr = 8'($urandom());
            tx_data = 8'($urandom());
            n++;
        end while (!tx_ready && n < budget);
    endtask

    task automatic wait_idle(input int budget, output int n, output bit saw_done);
        n = 0;
        saw_done = 1'b0;
        do begin
            @(negedge pclk);
            cfg_start = 1'b0;
            tx_valid  = 1'b0;
            if (done) saw_done = 1'b1;
            n++;
        end while (busy && n < budget);
        check("wait_idle_in_budget", busy, 1'b0);
    endtask

    task automatic send_byte(input logic [7:0] b, input int nfull, input int waits);
        int n;
        full_left = nfull;
        slv_waits = waits;
        check("tx_ready_before_byte", tx_ready, 1'b1);
        tx_data  = b;
        tx_valid = 1'b1;
        for (int i = 0; i <= nfull; i++) exp_q.push_back(rd(ADDR_FSR));
        exp_q.push_back(wr(ADDR_TDR, b));
        exp_q.push_back(wr(ADDR_OCR, sess_ocr | START_MASK));
        wait_ready(300, n);
        check("byte_latency", n, 1 + (nfull + 3) * (3 + waits));
    endtask

    // cfg_stop together with tx_valid: stop wins, no byte is taken.
    task automatic stop_session();
        cfg_stop = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'($urandom());
        #1;
        check("stop_tx_ready", tx_ready, 1'b0);
        @(negedge pclk);
        cfg_stop = 1'b0;
        tx_valid = 1'b0;
        check("stop_done_pulse", done, 1'b1);
        check("stop_busy", busy, 1'b0);
        @(negedge pclk);
        check("done_one_cycle", done, 1'b0);
        repeat (4) @(negedge pclk);
        check_log("after_stop");
    endtask

    initial begin : main
        int         n;
        bit         saw_done;
        bit         reached;
        logic [7:0] l, f, h, o;
        int         w;
        preset = 1'b1; cfg_start = 1'b0; cfg_stop = 1'b0;
        cfg_lcr = '0; cfg_fcr = '0; cfg_hcr = '0; cfg_ocr = '0;
        tx_data = '0; tx_valid = 1'b0;
        repeat (3) @(negedge pclk);
        check("rst_bus", {psel, penable, pwrite, paddr, pstrb, pwdata}, '0);
        check("rst_status", {tx_ready, busy, done, err}, '0);
        preset = 1'b0;
        @(negedge pclk);

        // Directed configuration, zero-wait slave.
        exp_cfg(8'h03, 8'h01, 8'h01, 8'h05, 4);
        start(8'h03, 8'h01, 8'h01, 8'h05);
        wait_ready(100, n);
        check("cfg_latency", n, 13);
        check_log("cfg_directed");

        send_byte(8'h0A, 0, 0);
        check_log("byte_0a");
        stop_session();

        // TX FIFO full on three polls, then a poll that never clears.
        l = 8'($urandom()); f = 8'($urandom()); h = 8'($urandom()); o = 8'($urandom());
        exp_cfg(l, f, h, o, 4);
        start(l, f, h, o);
        wait_ready(100, n);
        check("cfg2_latency", n, 13);
        send_byte(8'($urandom()), 3, 0);
        check_log("poll_three_full");
        full_forever = 1'b1;
        tx_data  = 8'($urandom());
        tx_valid = 1'b1;
        for (int i = 0; i < POLL_MAX; i++) exp_q.push_back(rd(ADDR_FSR));
        wait_idle(300, n, saw_done);
        full_forever = 1'b0;
        check("pollmax_err", err, 1'b1);
        check("pollmax_no_done", saw_done, 1'b0);
        check_log("pollmax");

        // Five wait states on every transfer and a slave error on the HCR write.
        slv_waits = 5;
        err_en    = 1'b1;
        err_addr  = ADDR_HCR;
        l = 8'($urandom()); f = 8'($urandom()); h = 8'($urandom()); o = 8'($urandom());
        exp_cfg(l, f, h, o, 3);
        start(l, f, h, o);
        @(negedge pclk);
        cfg_start = 1'b0;
        check("err_cleared_by_start", err, 1'b0);
        check("busy_after_start", busy, 1'b1);
        wait_idle(300, n, saw_done);
        check("slverr_err", err, 1'b1);
        check("slverr_no_done", saw_done, 1'b0);
        check_log("slverr_hcr");
        err_en = 1'b0;

        // Random configuration with random wait states, then random byte traffic.
        w = $urandom_range(0, 3);
        slv_waits = w;
        l = 8'($urandom()); f = 8'($urandom()); h = 8'($urandom()); o = 8'($urandom());
        exp_cfg(l, f, h, o, 4);
        start(l, f, h, o);
        wait_ready(200, n);
        check("cfg_rand_latency", n, 1 + 4 * (3 + w));
        check("err_cleared_next_session", err, 1'b0);
        check_log("cfg_random");
        for (int i = 0; i < 8; i++) begin
            send_byte(8'($urandom()), $urandom_range(0, POLL_MAX - 1), $urandom_range(0, 2));
            check_log("stream_random");
        end
        slv_waits = 0;
        stop_session();

        // Reset while the TDR write is stalled in ACCESS.
        l = 8'($urandom()); f = 8'($urandom()); h = 8'($urandom()); o = 8'($urandom());
        exp_cfg(l, f, h, o, 4);
        start(l, f, h, o);
        wait_ready(100, n);
        check_log("cfg_before_reset");
        hold_en   = 1'b1;
        hold_addr = ADDR_TDR;
        tx_data   = 8'($urandom());
        tx_valid  = 1'b1;
        exp_q.push_back(rd(ADDR_FSR));
        reached = 1'b0;
        for (int i = 0; i < 40 && !reached; i++) begin
            @(negedge pclk);
            tx_valid = 1'b0;
            if (psel && penable && paddr == ADDR_TDR) reached = 1'b1;
        end
        check("tdr_access_reached", reached, 1'b1);
        preset = 1'b1;
        @(negedge pclk);
        preset = 1'b0;
        check("rst_mid_access_bus", {psel, penable, pwrite, paddr, pstrb, pwdata}, '0);
        check("rst_mid_access_status", {tx_ready, busy, done, err}, '0);
        hold_en = 1'b0;
        check_log("reset_abort");

        l = 8'($urandom()); f = 8'($urandom()); h = 8'($urandom()); o = 8'($urandom());
        exp_cfg(l, f, h, o, 4);
        start(l, f, h, o);
        wait_ready(100, n);
        check("cfg_after_reset_latency", n, 13);
        send_byte(8'($urandom()), 0, 0);
        check_log("after_reset_session");
        stop_session();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
